serial_sub: RTL and testbench
=============================

// Module: serial_sub
// PURPOSE
//  Bit-serial two's-complement subtractor for the 4-bit CPU datapath: computes DIFF = A - B,
//  one bit per clock, LSB first, using a single full-adder cell and a carry flip-flop (A + ~B + 1).
//  Complements the combinational ripple-carry adder: the ALU uses it for SUB/CMP where area beats
//  latency. Start/busy/done handshake toward the control FSM; flags feed the status register.
// PARAMETERS
//  WIDTH    4    operand/result width in bits (>= 2); counter width = clog2(WIDTH)+1
// PORTS
//  clk     in   1      single system clock, rising edge
//  rst_n   in   1      asynchronous, active-low reset
//  start   in   1      request; sampled only in IDLE
//  a       in   WIDTH  minuend, two's complement; sampled on accepted start
//  b       in   WIDTH  subtrahend, two's complement; sampled on accepted start
//  busy    out  1      high from edge after accepted start through the DONE cycle
//  done    out  1      one-cycle pulse: diff/borrow/ovf valid
//  diff    out  WIDTH  result A - B modulo 2^WIDTH
//  borrow  out  1      unsigned borrow (a < b unsigned) = ~carry_out
//  ovf     out  1      signed overflow
// BEHAVIOUR
//  Reset (rst_n low, async): state=IDLE, busy=0, done=0, diff=0, borrow=0, ovf=0, internal regs 0.
//   Takes effect immediately, incl. mid-operation; partial result discarded, outputs forced to 0.
//  States: IDLE -> SHIFT -> DONE -> IDLE.
//  IDLE: busy=0, done=0. start=1 at edge E: latch a->sa, ~b->sb, carry=1, cnt=0, go SHIFT.
//  SHIFT: each edge: s = sa[0]^sb[0]^carry; carry <= majority(sa[0],sb[0],carry);
//   shift s into sr MSB end (sr >> 1); sa, sb >> 1; cnt++. After WIDTH edges (E+WIDTH): go DONE,
//   load diff<=final sr, borrow<=~final carry, ovf<=(a_msb!=b_msb)&&(diff_msb!=a_msb)
//   (operand MSBs captured at E).
//  DONE: done=1 for exactly one cycle (after edge E+WIDTH), busy=1; next edge -> IDLE.
//  Latency: start accepted at edge E -> done high in cycle following edge E+WIDTH (WIDTH+1 cycles
//   incl. DONE); throughput one op per WIDTH+2 cycles.
//  start while busy (SHIFT or DONE) is ignored, not queued; a/b changes after E have no effect.
//  start held high continuously: new op accepted on first IDLE edge after DONE.
//  diff/borrow/ovf change only on the DONE load; hold last result until next DONE or reset.
//  Width rule: all arithmetic modulo 2^WIDTH; no sign extension; carry is 1 bit.
//  Edge cases: a==b -> diff=0, borrow=0, ovf=0; b=most-negative -> ovf iff a>=0.
// TESTING (WIDTH=4)
//  T1 a=0011,b=0100 (3-4) -> diff=1111, borrow=1, ovf=0; done 5 cycles after start edge.
//  T2 a=0101,b=1001 (5-(-7)) -> diff=1100, borrow=1, ovf=1.
//  T3 a=1110,b=1101 (-2-(-3)) -> diff=0001, borrow=0, ovf=0; a=1000,b=0001 -> 0111, ovf=1, borrow=0.
//  T4 start pulsed again during SHIFT and in DONE with different a/b -> ignored; result of first op
//   only; busy never drops between; done pulses exactly once.
//  T5 rst_n low 2 cycles into SHIFT -> all outputs 0 immediately, no done; after release a new
//   op a=0111,b=0111 -> diff=0000, borrow=0, ovf=0.
//  T6 start held high, two back-to-back ops -> done pulses spaced exactly WIDTH+2 cycles apart;
//   diff holds first result until second done.

Source files
------------

// File: rtl/serial_sub.sv
// Bit-serial two's-complement subtractor: diff = a - b, LSB first, one bit per clock.
// A single full-adder cell and a carry flip-flop compute a + ~b + 1.
// The start/busy/done handshake faces the control FSM. borrow and ovf feed the status register.
module serial_sub #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             ovf
);

  localparam int unsigned CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StDone
  } state_e;

  state_e           state_q;
  logic [WIDTH-1:0] sa_q;     // minuend, shifted right each SHIFT cycle
  logic [WIDTH-1:0] sb_q;     // inverted subtrahend, shifted right each SHIFT cycle
  logic [WIDTH-1:0] sr_q;     // result bits enter at the MSB end
  logic             carry_q;
  logic [CW-1:0]    cnt_q;
  logic             a_msb_q;  // operand sign bits captured at accept, for overflow
  logic             b_msb_q;

  logic             s_bit;
  logic             c_next;
  logic [WIDTH-1:0] sr_next;
  logic             last_bit;

  // Full-adder cell on the current LSBs, plus the shift-register next value
  always_comb begin
    s_bit    = sa_q[0] ^ sb_q[0] ^ carry_q;
    c_next   = (sa_q[0] & sb_q[0]) | (sa_q[0] & carry_q) | (sb_q[0] & carry_q);
    sr_next  = {s_bit, sr_q[WIDTH-1:1]};
    last_bit = (cnt_q == CW'(WIDTH - 1));
  end

  // Control FSM, datapath registers and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      sa_q    <= '0;
      sb_q    <= '0;
      sr_q    <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      diff    <= '0;
      borrow  <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          done <= 1'b0;
          if (start) begin
            sa_q    <= a;
            sb_q    <= ~b;
            sr_q    <= '0;
            carry_q <= 1'b1;  // the +1 of the two's-complement negate
            cnt_q   <= '0;
            a_msb_q <= a[WIDTH-1];
            b_msb_q <= b[WIDTH-1];
            busy    <= 1'b1;
            state_q <= StShift;
          end else begin
            busy    <= 1'b0;
          end
        end

        StShift: begin
          sa_q    <= sa_q >> 1;
          sb_q    <= sb_q >> 1;
          sr_q    <= sr_next;
          carry_q <= c_next;
          cnt_q   <= cnt_q + CW'(1);
          if (last_bit) begin
            // s_bit is the result MSB on this final step
            diff    <= sr_next;
            borrow  <= ~c_next;
            ovf     <= (a_msb_q != b_msb_q) && (s_bit != a_msb_q);
            done    <= 1'b1;
            state_q <= StDone;
          end
        end

        StDone: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          state_q <= StIdle;
        end

        default: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_sub.sv
// Scoreboard bench for serial_sub (WIDTH=4). Stimulus pushes hand-computed results.
// The monitor pops and compares them whenever done pulses.
module tb_serial_sub;

  localparam int unsigned WIDTH = 4;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow;
  logic             ovf;

  typedef struct packed {
    logic [WIDTH-1:0] d;
    logic             br;
    logic             ov;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  int   done_cnt = 0;
  int   acc_cyc  = 0;

  serial_sub #(.WIDTH(WIDTH)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .diff   (diff),
    .borrow (borrow),
    .ovf    (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: on every done pulse, pop the oldest expectation and compare
  always @(negedge clk) begin
    if (rst_n === 1'b1 && done === 1'b1) begin
      done_cnt++;
      if (exp_q.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("diff", 32'(diff), 32'(e.d));
        check("borrow", 32'(borrow), 32'(e.br));
        check("ovf", 32'(ovf), 32'(e.ov));
        check("busy_in_done", 32'(busy), 32'd1);
      end
    end
  end

  // Main-process activity sits 1 time unit after the falling edge
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // Present an operation, let it be accepted on the next rising edge, then drop start
  task automatic issue(input logic [WIDTH-1:0] aa, input logic [WIDTH-1:0] bb,
                       input logic [WIDTH-1:0] ed, input logic eb, input logic eo);
    exp_t e;
    tick();
    a     = aa;
    b     = bb;
    start = 1'b1;
    e.d   = ed;
    e.br  = eb;
    e.ov  = eo;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    acc_cyc = cyc;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (done === 1'b1) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
    if (!seen) check("done_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int base;
    int d1;
    rst_n = 1'b0;
    start = 1'b0;
    a     = '0;
    b     = '0;
    #12;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_diff", 32'(diff), 32'd0);
    check("rst_flags", 32'({borrow, ovf}), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // T1: 3 - 4, plus the latency from the accepting edge to done
    issue(4'b0011, 4'b0100, 4'b1111, 1'b1, 1'b0);
    check("t1_busy", 32'(busy), 32'd1);
    wait_done();
    check("t1_latency", 32'(cyc - acc_cyc), 32'(WIDTH));
    tick();
    tick();

    // T2 / T3 / most-negative subtrahend cases
    issue(4'b0101, 4'b1001, 4'b1100, 1'b1, 1'b1);
    wait_done();
    issue(4'b1110, 4'b1101, 4'b0001, 1'b0, 1'b0);
    wait_done();
    issue(4'b1000, 4'b0001, 4'b0111, 1'b0, 1'b1);
    wait_done();
    issue(4'b1111, 4'b1000, 4'b0111, 1'b0, 1'b0);
    wait_done();
    tick();

    // T4: starts during SHIFT and DONE are ignored
    issue(4'b0110, 4'b0010, 4'b0100, 1'b0, 1'b0);
    a     = 4'b1111;
    b     = 4'b0001;
    start = 1'b1;
    check("t4_busy_shift", 32'(busy), 32'd1);
    tick();
    start = 1'b0;
    check("t4_busy_shift2", 32'(busy), 32'd1);
    wait_done();
    check("t4_busy_done", 32'(busy), 32'd1);
    a     = 4'b1010;
    b     = 4'b0101;
    start = 1'b1;
    base  = done_cnt;
    tick();
    start = 1'b0;
    check("t4_busy_idle", 32'(busy), 32'd0);
    check("t4_done_low", 32'(done), 32'd0);
    for (int i = 0; i < 3; i++) tick();
    check("t4_single_done", 32'(done_cnt), 32'(base));
    check("t4_busy_stays_low", 32'(busy), 32'd0);
    check("t4_diff_held", 32'(diff), 32'b0100);

    // T5: asynchronous reset two cycles into SHIFT
    issue(4'b0001, 4'b0011, 4'b1110, 1'b1, 1'b0);
    tick();
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    check("t5_busy", 32'(busy), 32'd0);
    check("t5_done", 32'(done), 32'd0);
    check("t5_diff", 32'(diff), 32'd0);
    check("t5_flags", 32'({borrow, ovf}), 32'd0);
    base = done_cnt;
    tick();
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    check("t5_no_done", 32'(done_cnt), 32'(base));
    issue(4'b0111, 4'b0111, 4'b0000, 1'b0, 1'b0);
    wait_done();
    tick();

    // T6: start held high, two back-to-back operations
    tick();
    a     = 4'b0010;
    b     = 4'b0011;
    start = 1'b1;
    exp_q.push_back(exp_t'({4'b1111, 1'b1, 1'b0}));
    tick();
    wait_done();
    d1 = cyc;
    a  = 4'b0000;
    b  = 4'b1000;
    exp_q.push_back(exp_t'({4'b1000, 1'b1, 1'b1}));
    tick();
    check("t6_hold_idle", 32'(diff), 32'b1111);
    tick();
    start = 1'b0;
    check("t6_hold_shift", 32'(diff), 32'b1111);
    check("t6_busy_second", 32'(busy), 32'd1);
    wait_done();
    check("t6_spacing", 32'(cyc - d1), 32'(WIDTH + 2));
    tick();
    tick();

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
